// File: rtl/div_unit_if.sv
// Handshake bundle between the execute stage and the iterative divider.
// The pipeline side (master) issues operands and control; the divider side
// (slave) returns the stall request, the completion pulse and the results.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             div_running;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_div, a, b, cancel,
        input  div_running, done, quotient, remainder
    );

    modport slave (
        input  start, signed_div, a, b, cancel,
        output div_running, done, quotient, remainder
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU. One quotient bit per clock on
// operand magnitudes, sign fix-up applied while registering the results.
// div_running stalls the pipeline from the accept cycle until the result
// cycle; done pulses once when quotient/remainder are updated.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic             accept;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] dividendReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic             signQ;
    logic             signR;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1),
    // which is still correct when read as an unsigned magnitude.
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    assign magA = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign magB = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // One restoring step. The partial remainder is always below the divisor,
    // so bit WIDTH of the trial difference is exactly its sign.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trialOk;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    assign shifted = {remReg, dividendReg[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisorReg};
    assign trialOk = ~trial[WIDTH];
    assign remNext = trialOk ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quoNext = {quoReg[WIDTH-2:0], trialOk};

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode plus the stall and completion outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value held, which would infer a latch.
        stateNext       = state;
        accept          = 1'b0;
        bus.div_running = 1'b0;
        bus.done        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    accept          = 1'b1;
                    bus.div_running = 1'b1;
                    stateNext       = (bus.b == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                bus.div_running = 1'b1;
                if (counter == CW'(1)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                // start is still held by the departing instruction here.
                bus.done  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (bus.cancel) begin
            stateNext = IDLE;
        end
    end

    // Datapath: operand capture, iteration and result registration.
    always_ff @(posedge clk) begin
        // NOTE: datapath and result registers are reset as well, so the
        // HI/LO values read after reset are defined zeros, not X.
        if (rst) begin
            counter       <= '0;
            dividendReg   <= '0;
            divisorReg    <= '0;
            remReg        <= '0;
            quoReg        <= '0;
            signQ         <= 1'b0;
            signR         <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.b == '0) begin
                            // Divide-by-zero: fixed pattern, no iteration.
                            bus.quotient  <= '1;
                            bus.remainder <= bus.a;
                        end else begin
                            dividendReg <= magA;
                            divisorReg  <= magB;
                            signQ       <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            signR       <= bus.signed_div & bus.a[WIDTH-1];
                            remReg      <= '0;
                            quoReg      <= '0;
                            counter     <= CW'(WIDTH);
                        end
                    end
                end
                BUSY: begin
                    // A cancel on the last step must leave the old results.
                    if (!bus.cancel) begin
                        remReg      <= remNext;
                        quoReg      <= quoNext;
                        dividendReg <= dividendReg << 1;
                        counter     <= counter - CW'(1);
                        if (counter == CW'(1)) begin
                            bus.quotient  <= signQ ? -quoNext : quoNext;
                            bus.remainder <= signR ? -remNext : remNext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases with literal results and
// latencies, reset/cancel aborts, back-to-back issue, then random divisions.
// A behavioural model predicts stall, done and result values every cycle.
module tb_div_unit;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(WIDTH)) bus ();

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference result {remainder, quotient} from plain integer arithmetic.
    // Signed case uses 64-bit math so MIN/-1 wraps naturally.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (sgn) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {av % bv, av / bv};
    endfunction

    // Behavioural model: an accepted divide stalls for WIDTH+1 cycles and
    // the result appears one cycle later; b==0 finishes the next cycle.
    logic        mValid = 1'b0;
    logic        mBusy;
    logic        mDone;
    int          mLeft;
    logic [31:0] mQ;
    logic [31:0] mR;
    logic [31:0] pendQ;
    logic [31:0] pendR;

    always @(posedge clk) begin
        if (rst) begin
            mValid <= 1'b1;
            mBusy  <= 1'b0;
            mDone  <= 1'b0;
            mLeft  <= 0;
            mQ     <= '0;
            mR     <= '0;
        end else if (mValid) begin
            if (bus.cancel) begin
                mBusy <= 1'b0;
                mDone <= 1'b0;
            end else if (mDone) begin
                mDone <= 1'b0;
            end else if (mBusy) begin
                mLeft <= mLeft - 1;
                if (mLeft == 1) begin
                    mBusy <= 1'b0;
                    mDone <= 1'b1;
                    mQ    <= pendQ;
                    mR    <= pendR;
                end
            end else if (bus.start) begin
                if (bus.b == '0) begin
                    mDone <= 1'b1;
                    mQ    <= '1;
                    mR    <= bus.a;
                end else begin
                    mBusy          <= 1'b1;
                    mLeft          <= WIDTH;
                    {pendR, pendQ} <= refDiv(bus.signed_div, bus.a, bus.b);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mValid) begin
            check("div_running", bus.div_running,
                  mBusy || (!mDone && bus.start && !bus.cancel));
            check("done", bus.done, mDone);
            check("quotient", bus.quotient, mQ);
            check("remainder", bus.remainder, mR);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.start  = 1'b0;
            bus.cancel = 1'b0;
        end
    endtask

    // Issue one divide and follow it to its done cycle. start stays high
    // through the done cycle, as the stalled pipeline would hold it.
    task automatic runDirected(input string name, input logic sgn, input logic [31:0] av,
                               input logic [31:0] bv, input logic [31:0] expQ,
                               input logic [31:0] expR, input int expLat);
        int stalls;
        int doneAt;
        stalls = 0;
        doneAt = -1;
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.cancel     = 1'b0;
        bus.signed_div = sgn;
        bus.a          = av;
        bus.b          = bv;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.div_running) stalls++;
            if (bus.done) begin
                doneAt = n;
                break;
            end
            @(posedge clk);
            #1;
            bus.a = $urandom;
            bus.b = $urandom;
        end
        check({name, " done cycle"}, doneAt, expLat);
        check({name, " stall cycles"}, stalls, expLat);
        check({name, " quotient"}, bus.quotient, expQ);
        check({name, " remainder"}, bus.remainder, expR);
    endtask

    // Start DIVU 100/7 and abort it in cycle 10 with reset or cancel.
    task automatic abortAt10(input logic useReset);
        logic doneSeen;
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.a          = 32'd100;
        bus.b          = 32'd7;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        if (useReset) rst = 1'b1;
        else bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.cancel = 1'b0;
        bus.start  = 1'b0;
        @(negedge clk);
        check("abort div_running", bus.div_running, 1'b0);
        doneSeen = 1'b0;
        repeat (36) begin
            @(negedge clk);
            if (bus.done) doneSeen = 1'b1;
        end
        check("abort no done", doneSeen, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic        finished;
        logic        sgn;
        logic [31:0] av;
        logic [31:0] bv;
        int          cancelAt;
        int          sel;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.cancel     = 1'b0;
        bus.signed_div = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset quotient", bus.quotient, 32'h0);
        check("reset remainder", bus.remainder, 32'h0);
        check("reset done", bus.done, 1'b0);
        check("reset div_running", bus.div_running, 1'b0);

        runDirected("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        idle(2);
        runDirected("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        idle(1);
        runDirected("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        idle(1);
        runDirected("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33);
        idle(1);
        runDirected("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 33);
        idle(1);
        runDirected("div by zero", 1'b0, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 32'h0000_1234, 1);
        idle(2);

        abortAt10(1'b1);
        check("reset abort quotient", bus.quotient, 32'h0);
        runDirected("divu 9/3 after reset", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
        idle(2);
        abortAt10(1'b0);
        check("cancel keeps quotient", bus.quotient, 32'd3);
        check("cancel keeps remainder", bus.remainder, 32'd0);
        runDirected("divu 9/3 after cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
        idle(2);

        // start together with cancel in IDLE is not accepted.
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.a      = 32'd5;
        bus.b      = 32'd1;
        @(negedge clk);
        check("start+cancel div_running", bus.div_running, 1'b0);
        idle(1);
        @(negedge clk);
        check("start+cancel no accept", bus.div_running, 1'b0);
        check("start+cancel quotient kept", bus.quotient, 32'd3);

        // Back-to-back: each new start lands in the first IDLE after DONE.
        runDirected("b2b divu 50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 33);
        runDirected("b2b div -20/3", 1'b1, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 33);
        runDirected("b2b div by zero", 1'b1, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1);
        idle(2);

        // Randomized divisions, some cancelled part-way.
        for (int k = 0; k < 25; k++) begin
            sgn = 1'($urandom_range(0, 1));
            av  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       bv = 32'h0;
                1:       bv = 32'h1;
                2:       bv = 32'hFFFF_FFFF;
                3:       bv = 32'($urandom_range(1, 15));
                default: bv = $urandom;
            endcase
            cancelAt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 34) : -1;
            @(posedge clk);
            #1;
            bus.start      = 1'b1;
            bus.cancel     = 1'b0;
            bus.signed_div = sgn;
            bus.a          = av;
            bus.b          = bv;
            finished = 1'b0;
            for (int n = 0; n < 40 && !finished; n++) begin
                @(negedge clk);
                if (bus.done) begin
                    finished = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                    bus.a = $urandom;
                    bus.b = $urandom;
                    if (bus.cancel) begin
                        bus.cancel = 1'b0;
                        bus.start  = 1'b0;
                        finished   = 1'b1;
                    end else if (n + 1 == cancelAt) begin
                        bus.cancel = 1'b1;
                    end
                end
            end
            check("random op finished", finished, 1'b1);
            idle($urandom_range(1, 3));
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative integer divider for the 5-stage MIPS pipeline, executing DIV/DIVU issued from the execute stage.
- Produces the `div_running` level that the hazard unit uses to stall F/D/E/M/W while a division is in flight.
- Delivers quotient (LO) and remainder (HI) on completion.
- Radix-2 restoring algorithm: one quotient bit per clock.

Parameters:
WIDTH, 32, operand/result width in bits (counter sized to hold WIDTH).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  E-stage holds a DIV/DIVU instruction; held high by the pipeline for as long as E is stalled
signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
a  input  WIDTH  dividend (rs value, already forwarded)
b  input  WIDTH  divisor (rt value, already forwarded)
cancel  input  1  exception/flush of the E-stage instruction; aborts any division
div_running  output  1  to hazard unit; stall request
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  registered quotient, written to LO
remainder  output  WIDTH  registered remainder, written to HI

Behaviour:
- The block has one clock and a synchronous, active-high reset. In a rising-edge cycle with rst=1:
  - state←IDLE, counter←0;
  - quotient, remainder and internal registers←0;
  - done=0 and div_running=0 in the following cycle.
  - Reset mid-division discards the operation with no done pulse.
- States:
  - IDLE: waiting.
  - BUSY: iterating.
  - DONE: result cycle.
- div_running (combinational) = (state==IDLE & start & !cancel) | state==BUSY. It is never high in DONE, so the stall releases in the DONE cycle and the instruction leaves E at the end of it.
- IDLE → BUSY when start & !cancel & b!=0. On the accept edge:
  - latch |a| and |b| (magnitudes when signed_div, raw otherwise);
  - latch sign_q = a[W-1]^b[W-1] and sign_r = a[W-1] (both forced 0 when unsigned);
  - partial remainder←0, counter←WIDTH.
- IDLE → DONE when start & !cancel & b==0 (divide-by-zero):
  - quotient←all ones, remainder←a;
  - div_running high for the accept cycle only.
- BUSY, each cycle:
  - trial = {rem[W-1:0], dividend_msb} − divisor, computed W+1 bits wide;
  - if trial is non-negative: rem←trial, shift 1 into the quotient; else rem←the shifted value, shift 0 into the quotient;
  - dividend shifts left by 1;
  - counter decrements.
- BUSY → DONE when counter==1 at the edge, i.e. after WIDTH iterations.
- On BUSY → DONE, the sign fix-up is applied while registering the outputs:
  - quotient←sign_q ? −q : q;
  - remainder←sign_r ? −r : r.
- DONE: done=1 for exactly one cycle; unconditionally → IDLE next edge. start is ignored in DONE; it is still high from the departing instruction.
- Latency (accept cycle = cycle 0):
  - div_running high in cycles 0..WIDTH, i.e. 33 cycles for WIDTH=32;
  - done in cycle WIDTH+1;
  - quotient/remainder valid from cycle WIDTH+1 and held until the next divide completes.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (natural wrap, no trap).
- cancel:
  - in any state it forces → IDLE on the next edge;
  - no done pulse, outputs keep their previous values;
  - while in IDLE, cancel suppresses acceptance.
- start with cancel in the same IDLE cycle: the division is not accepted and div_running=0.
- Operands a/b are only sampled on the accept edge. Changes during BUSY have no effect.

Test Plan:
- DIVU a=100, b=7 → div_running high cycles 0–32, done pulse cycle 33, quotient=14, remainder=2.
- DIV a=0xFFFFFFF9 (−7), b=2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). DIV a=7, b=0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
- DIV a=0x80000000, b=0xFFFFFFFF → quotient=0x80000000, remainder=0. DIVU 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
- b=0, a=0x1234 → div_running high cycle 0 only, done cycle 1, quotient=0xFFFFFFFF, remainder=0x1234.
- Start DIVU 100/7, assert rst in cycle 10 → div_running=0 from cycle 11, no done; then DIVU 9/3 completes with quotient=3, remainder=0 after 33 stall cycles. Repeat with cancel in cycle 10 → identical, prior quotient/remainder retained.
- Back-to-back: hold start high through DONE → no restart in DONE. A new start in the first IDLE cycle after DONE is accepted, and done does not pulse twice for one instruction.
